// File: rtl/ddcpu_packet_loader.sv
// Packet loader: reads a six-word template at OPADDR+dest_addr, merges request fields, routes by opmode.
// Latency: 1 cycle accept->first address, 2 cycles per word, 1 cycle to output valid; all outputs registered.
// Backpressure: every channel stalls indefinitely without loss; PACKET_LOADER_ADDR_ALIGN_EN forces addr[1:0]=0.
module ddcpu_packet_loader #(
    parameter int PACKET_WIDTH         = 175,
    parameter int PACKET_REQUEST_WIDTH = 115
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [31:0]                     OPADDR,
    output logic                            MEM_SEND_ADDR_VALID,
    output logic [31:0]                     MEM_SEND_ADDR,
    output logic                            MEM_SEND_DATA_VALID,
    output logic [31:0]                     MEM_SEND_DATA,
    input  logic                            MEM_SEND_READY,
    input  logic                            MEM_RECEIVE_VALID,
    input  logic [31:0]                     MEM_RECEIVE_DATA,
    output logic                            MEM_RECEIVE_READY,
    input  logic                            RECEIVE_PR_VALID,
    input  logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR_DATA,
    output logic                            RECEIVE_PR_READY,
    output logic                            SEND_PC_TO_QU_VALID,
    output logic [PACKET_WIDTH-1:0]         SEND_PC_TO_QU_DATA,
    input  logic                            SEND_PC_TO_QU_READY,
    output logic                            SEND_PC_TO_FE_VALID,
    output logic [PACKET_WIDTH-1:0]         SEND_PC_TO_FE_DATA,
    input  logic                            SEND_PC_TO_FE_READY,
    output logic                            SEND_PC_TO_MA_VALID,
    output logic [PACKET_WIDTH-1:0]         SEND_PC_TO_MA_DATA,
    input  logic                            SEND_PC_TO_MA_READY
);

    localparam logic [1:0] OPCODE_EI = 2'd0;
    localparam logic [1:0] OPCODE_FN = 2'd1;
    localparam logic [1:0] OPCODE_MA = 2'd2;
    localparam logic [2:0] DEST_OPTION_EXEC  = 3'd0;
    localparam logic [2:0] DEST_OPTION_LEFT  = 3'd1;
    localparam logic [2:0] DEST_OPTION_RIGHT = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      k_q, k_d;
    logic [PACKET_REQUEST_WIDTH-1:0] req_q, req_d;
    logic [PACKET_WIDTH-1:0]         pkt_q, pkt_d;
    logic [PACKET_WIDTH-1:0]         out_dat_q, out_dat_d;
    logic [2:0]                      out_vld_q, out_vld_d;   // {MA, FE, QU}
    logic                            addr_vld_q, addr_vld_d;
    logic [31:0]                     addr_q, addr_d;
    logic                            rcv_rdy_q, rcv_rdy_d;
    logic                            pr_rdy_q, pr_rdy_d;
    logic [PACKET_WIDTH-1:0]         merged;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] dst,
                                              input logic [2:0]  k);
        logic [31:0] a;
        a = base + {16'b0, dst} + {27'b0, k, 2'b00};
`ifdef PACKET_LOADER_ADDR_ALIGN_EN
        a[1:0] = 2'b00;
`else
`endif
        return a;
    endfunction

    function automatic logic [PACKET_WIDTH-1:0] merge_req(input logic [PACKET_WIDTH-1:0]         tmpl,
                                                          input logic [PACKET_REQUEST_WIDTH-1:0] req);
        logic [PACKET_WIDTH-1:0] m;
        m = tmpl;
        m[95:64] = req[95:64];
        case (req[114:112])
            DEST_OPTION_EXEC: begin
                m[63:32] = req[63:32];
                m[31:0]  = req[31:0];
            end
            DEST_OPTION_LEFT:  m[63:32] = req[63:32];
            DEST_OPTION_RIGHT: m[31:0]  = req[31:0];
            default: ;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        req_d      = req_q;
        pkt_d      = pkt_q;
        out_dat_d  = out_dat_q;
        out_vld_d  = out_vld_q;
        addr_vld_d = addr_vld_q;
        addr_d     = addr_q;
        rcv_rdy_d  = rcv_rdy_q;
        pr_rdy_d   = pr_rdy_q;
        merged     = '0;

        case (state_q)
            IDLE: begin
                pr_rdy_d = 1'b1;
                if (RECEIVE_PR_VALID && pr_rdy_q) begin
                    req_d      = RECEIVE_PR_DATA;
                    k_d        = 3'd0;
                    pr_rdy_d   = 1'b0;
                    addr_vld_d = 1'b1;
                    addr_d     = word_addr(OPADDR, RECEIVE_PR_DATA[111:96], 3'd0);
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (MEM_SEND_READY) begin
                    addr_vld_d = 1'b0;
                    rcv_rdy_d  = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (MEM_RECEIVE_VALID) begin
                    rcv_rdy_d = 1'b0;
                    case (k_q)
                        3'd0:    pkt_d[174:143] = MEM_RECEIVE_DATA;
                        3'd1:    pkt_d[142:111] = MEM_RECEIVE_DATA;
                        3'd2:    pkt_d[110:79]  = MEM_RECEIVE_DATA;
                        3'd3:    pkt_d[78:47]   = MEM_RECEIVE_DATA;
                        3'd4:    pkt_d[46:15]   = MEM_RECEIVE_DATA;
                        default: pkt_d[14:0]    = MEM_RECEIVE_DATA[14:0];
                    endcase
                    if (k_q < 3'd5) begin
                        k_d        = k_q + 3'd1;
                        addr_vld_d = 1'b1;
                        addr_d     = word_addr(OPADDR, req_q[111:96], k_q + 3'd1);
                        state_d    = ADDR;
                    end else begin
                        merged    = merge_req(pkt_d, req_q);
                        out_dat_d = merged;
                        state_d   = SEND;
                        case (merged[174:173])
                            OPCODE_EI: out_vld_d = 3'b001;
                            OPCODE_FN: out_vld_d = 3'b010;
                            OPCODE_MA: out_vld_d = 3'b100;
                            default: begin
                                // opmode 3 has no consumer: drop the packet
                                out_vld_d = 3'b000;
                                pr_rdy_d  = 1'b1;
                                state_d   = IDLE;
                            end
                        endcase
                    end
                end
            end
            SEND: begin
                if (|(out_vld_q & {SEND_PC_TO_MA_READY, SEND_PC_TO_FE_READY, SEND_PC_TO_QU_READY})) begin
                    out_vld_d = 3'b000;
                    pr_rdy_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            req_q      <= '0;
            pkt_q      <= '0;
            out_dat_q  <= '0;
            out_vld_q  <= 3'b000;
            addr_vld_q <= 1'b0;
            addr_q     <= 32'd0;
            rcv_rdy_q  <= 1'b0;
            pr_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            req_q      <= req_d;
            pkt_q      <= pkt_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
            addr_vld_q <= addr_vld_d;
            addr_q     <= addr_d;
            rcv_rdy_q  <= rcv_rdy_d;
            pr_rdy_q   <= pr_rdy_d;
        end
    end

    assign MEM_SEND_ADDR_VALID = addr_vld_q;
    assign MEM_SEND_ADDR       = addr_q;
    assign MEM_SEND_DATA_VALID = 1'b0;
    assign MEM_SEND_DATA       = 32'd0;
    assign MEM_RECEIVE_READY   = rcv_rdy_q;
    assign RECEIVE_PR_READY    = pr_rdy_q;
    assign SEND_PC_TO_QU_VALID = out_vld_q[0];
    assign SEND_PC_TO_FE_VALID = out_vld_q[1];
    assign SEND_PC_TO_MA_VALID = out_vld_q[2];
    assign SEND_PC_TO_QU_DATA  = out_dat_q;
    assign SEND_PC_TO_FE_DATA  = out_dat_q;
    assign SEND_PC_TO_MA_DATA  = out_dat_q;

endmodule

// File: tb/tb_ddcpu_packet_loader.sv
// Directed bench for ddcpu_packet_loader: hand-built templates and requests, immediate-assertion checks.
module tb_ddcpu_packet_loader;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [31:0]  OPADDR = 32'd0;
    logic         MEM_SEND_ADDR_VALID;
    logic [31:0]  MEM_SEND_ADDR;
    logic         MEM_SEND_DATA_VALID;
    logic [31:0]  MEM_SEND_DATA;
    logic         MEM_SEND_READY = 1'b0;
    logic         MEM_RECEIVE_VALID = 1'b0;
    logic [31:0]  MEM_RECEIVE_DATA = 32'd0;
    logic         MEM_RECEIVE_READY;
    logic         RECEIVE_PR_VALID = 1'b0;
    logic [114:0] RECEIVE_PR_DATA = '0;
    logic         RECEIVE_PR_READY;
    logic         SEND_PC_TO_QU_VALID, SEND_PC_TO_FE_VALID, SEND_PC_TO_MA_VALID;
    logic [174:0] SEND_PC_TO_QU_DATA, SEND_PC_TO_FE_DATA, SEND_PC_TO_MA_DATA;
    logic         SEND_PC_TO_QU_READY = 1'b0;
    logic         SEND_PC_TO_FE_READY = 1'b0;
    logic         SEND_PC_TO_MA_READY = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ddcpu_packet_loader dut (
        .CLK(CLK), .RST(RST), .OPADDR(OPADDR),
        .MEM_SEND_ADDR_VALID(MEM_SEND_ADDR_VALID), .MEM_SEND_ADDR(MEM_SEND_ADDR),
        .MEM_SEND_DATA_VALID(MEM_SEND_DATA_VALID), .MEM_SEND_DATA(MEM_SEND_DATA),
        .MEM_SEND_READY(MEM_SEND_READY),
        .MEM_RECEIVE_VALID(MEM_RECEIVE_VALID), .MEM_RECEIVE_DATA(MEM_RECEIVE_DATA),
        .MEM_RECEIVE_READY(MEM_RECEIVE_READY),
        .RECEIVE_PR_VALID(RECEIVE_PR_VALID), .RECEIVE_PR_DATA(RECEIVE_PR_DATA),
        .RECEIVE_PR_READY(RECEIVE_PR_READY),
        .SEND_PC_TO_QU_VALID(SEND_PC_TO_QU_VALID), .SEND_PC_TO_QU_DATA(SEND_PC_TO_QU_DATA),
        .SEND_PC_TO_QU_READY(SEND_PC_TO_QU_READY),
        .SEND_PC_TO_FE_VALID(SEND_PC_TO_FE_VALID), .SEND_PC_TO_FE_DATA(SEND_PC_TO_FE_DATA),
        .SEND_PC_TO_FE_READY(SEND_PC_TO_FE_READY),
        .SEND_PC_TO_MA_VALID(SEND_PC_TO_MA_VALID), .SEND_PC_TO_MA_DATA(SEND_PC_TO_MA_DATA),
        .SEND_PC_TO_MA_READY(SEND_PC_TO_MA_READY)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [174:0] obs, input logic [174:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] out_vlds();
        return {SEND_PC_TO_MA_VALID, SEND_PC_TO_FE_VALID, SEND_PC_TO_QU_VALID};
    endfunction

    // wv holds the six template words, word 0 in the top 32 bits
    task automatic run_req(input string tag, input logic [31:0] opaddr, input logic [114:0] req,
                           input logic [191:0] wv, input logic [31:0] exp_base,
                           input int stall_addr_k, input int stall_rcv_k, input bit stall_out,
                           input int rst_after);
        logic [174:0] tmpl, exp_pkt, obs_pkt;
        logic [1:0]   op;
        logic [2:0]   exp_vld;
        logic [31:0]  w;

        tmpl    = {wv[191:32], wv[14:0]};
        exp_pkt = tmpl;
        exp_pkt[95:64] = req[95:64];
        case (req[114:112])
            3'd0: begin exp_pkt[63:32] = req[63:32]; exp_pkt[31:0] = req[31:0]; end
            3'd1: exp_pkt[63:32] = req[63:32];
            3'd2: exp_pkt[31:0]  = req[31:0];
            default: ;
        endcase
        op = wv[191:190];
        case (op)
            2'd0:    exp_vld = 3'b001;
            2'd1:    exp_vld = 3'b010;
            2'd2:    exp_vld = 3'b100;
            default: exp_vld = 3'b000;
        endcase

        OPADDR = opaddr;
        RECEIVE_PR_DATA = req;
        RECEIVE_PR_VALID = 1'b1;
        chk({tag, "/pr_rdy_idle"}, RECEIVE_PR_READY, 1'b1);
        tick;
        RECEIVE_PR_VALID = 1'b0;
        chk({tag, "/pr_rdy_busy"}, RECEIVE_PR_READY, 1'b0);

        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s/addr_vld%0d", tag, k), MEM_SEND_ADDR_VALID, 1'b1);
            chk($sformatf("%s/addr%0d", tag, k), MEM_SEND_ADDR, exp_base + 32'(4 * k));
            if (k == stall_addr_k) begin
                repeat (5) tick;
                chk($sformatf("%s/addr_hold_vld%0d", tag, k), MEM_SEND_ADDR_VALID, 1'b1);
                chk($sformatf("%s/addr_hold%0d", tag, k), MEM_SEND_ADDR, exp_base + 32'(4 * k));
            end
            MEM_SEND_READY = 1'b1;
            tick;
            MEM_SEND_READY = 1'b0;
            chk($sformatf("%s/addr_drop%0d", tag, k), MEM_SEND_ADDR_VALID, 1'b0);
            chk($sformatf("%s/rcv_rdy%0d", tag, k), MEM_RECEIVE_READY, 1'b1);
            if (k == stall_rcv_k) begin
                repeat (5) tick;
                chk($sformatf("%s/rcv_hold%0d", tag, k), MEM_RECEIVE_READY, 1'b1);
                chk($sformatf("%s/no_dup_addr%0d", tag, k), MEM_SEND_ADDR_VALID, 1'b0);
            end
            w = wv[32*(5-k) +: 32];
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA = w;
            tick;
            MEM_RECEIVE_VALID = 1'b0;
            MEM_RECEIVE_DATA = 32'd0;
            chk($sformatf("%s/rcv_drop%0d", tag, k), MEM_RECEIVE_READY, 1'b0);
            if (k == rst_after) begin
                RST = 1'b1;
                tick;
                RST = 1'b0;
                chk({tag, "/rst_pr_rdy"}, RECEIVE_PR_READY, 1'b0);
                chk({tag, "/rst_vlds"}, {out_vlds(), MEM_SEND_ADDR_VALID, MEM_RECEIVE_READY}, 5'b0);
                chk({tag, "/rst_addr"}, MEM_SEND_ADDR, 32'd0);
                tick;
                chk({tag, "/rst_pr_up"}, RECEIVE_PR_READY, 1'b1);
                chk({tag, "/rst_no_pkt"}, {out_vlds(), MEM_SEND_ADDR_VALID}, 4'b0);
                return;
            end
        end

        chk({tag, "/out_vld"}, out_vlds(), exp_vld);
        if (op == 2'd3) begin
            chk({tag, "/discard_pr_rdy"}, RECEIVE_PR_READY, 1'b1);
            return;
        end
        case (op)
            2'd0:    obs_pkt = SEND_PC_TO_QU_DATA;
            2'd1:    obs_pkt = SEND_PC_TO_FE_DATA;
            default: obs_pkt = SEND_PC_TO_MA_DATA;
        endcase
        chk({tag, "/out_dat"}, obs_pkt, exp_pkt);
        chk({tag, "/pr_rdy_send"}, RECEIVE_PR_READY, 1'b0);
        if (stall_out) begin
            repeat (5) tick;
            chk({tag, "/out_vld_hold"}, out_vlds(), exp_vld);
            case (op)
                2'd0:    obs_pkt = SEND_PC_TO_QU_DATA;
                2'd1:    obs_pkt = SEND_PC_TO_FE_DATA;
                default: obs_pkt = SEND_PC_TO_MA_DATA;
            endcase
            chk({tag, "/out_dat_hold"}, obs_pkt, exp_pkt);
        end
        SEND_PC_TO_QU_READY = 1'b1;
        SEND_PC_TO_FE_READY = 1'b1;
        SEND_PC_TO_MA_READY = 1'b1;
        tick;
        SEND_PC_TO_QU_READY = 1'b0;
        SEND_PC_TO_FE_READY = 1'b0;
        SEND_PC_TO_MA_READY = 1'b0;
        chk({tag, "/out_drop"}, out_vlds(), 3'b000);
        chk({tag, "/pr_rdy_back"}, RECEIVE_PR_READY, 1'b1);
    endtask

    initial begin
        // reset held: every handshake output low
        tick;
        tick;
        chk("rst/pr_rdy", RECEIVE_PR_READY, 1'b0);
        chk("rst/addr_vld", MEM_SEND_ADDR_VALID, 1'b0);
        chk("rst/out_vlds", out_vlds(), 3'b000);
        chk("rst/wr_tied", {MEM_SEND_DATA_VALID, MEM_SEND_DATA}, 33'd0);
        RST = 1'b0;
        tick;
        chk("rst/pr_rdy_release", RECEIVE_PR_READY, 1'b1);

        // EI + EXEC: address sequence from 0x2000_0010
        run_req("ei_exec", 32'h2000_0000,
                {3'd0, 16'h0010, 32'hC0C0_0001, 32'hD1D1_0001, 32'hD2D2_0001},
                {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4, 32'h0000_2AAA},
                32'h2000_0010, -1, -1, 1'b0, -1);

        // FN + LEFT with address and output stalls
        run_req("fn_left", 32'h0000_1000,
                {3'd1, 16'h0100, 32'hCAFE_BABE, 32'h1111_2222, 32'h3333_4444},
                {32'h5555_AAAA, 32'hFFFF_0000, 32'h0000_FFFF, 32'hA5A5_5A5A, 32'h0123_4567, 32'h89AB_CDEF},
                32'h0000_1100, 1, -1, 1'b1, -1);

        // MA + RIGHT, word 5 carries ones above bit 14, receive stall on word 3
        run_req("ma_right", 32'h0000_4000,
                {3'd2, 16'h0020, 32'h0BAD_F00D, 32'h7777_8888, 32'h9999_AAAA},
                {32'h8000_0001, 32'h2222_3333, 32'h4444_5555, 32'h6666_7777, 32'h8888_9999, 32'hFFFF_9234},
                32'h0000_4020, -1, 3, 1'b1, -1);

        // EI with an unused dest_option: only color replaced
        run_req("ei_opt5", 32'h0000_0000,
                {3'd5, 16'h0040, 32'hFEED_FACE, 32'hDEAD_0001, 32'hDEAD_0002},
                {32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_7FFF},
                32'h0000_0040, -1, -1, 1'b0, -1);

        // opmode 3 is discarded
        run_req("op3_drop", 32'h0000_0800,
                {3'd0, 16'h0000, 32'h1, 32'h2, 32'h3},
                {32'hC000_0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
                32'h0000_0800, -1, -1, 1'b0, -1);

        // address wraps past 2^32
        run_req("wrap", 32'hFFFF_FFF0,
                {3'd1, 16'h0014, 32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000},
                {32'h4000_0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
                32'h0000_0004, -1, -1, 1'b0, -1);

        // unaligned dest_addr passes through unchanged
        run_req("unaligned", 32'h0000_1000,
                {3'd2, 16'h0003, 32'h0, 32'h0, 32'h0},
                {32'h0000_0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
                32'h0000_1003, -1, -1, 1'b0, -1);

        // reset after word 2 drops the packet; next request completes
        run_req("mid_rst", 32'h2000_0000,
                {3'd0, 16'h0010, 32'h1, 32'h2, 32'h3},
                {32'h4000_0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
                32'h2000_0010, -1, -1, 1'b0, 2);
        run_req("after_rst", 32'h3000_0000,
                {3'd0, 16'h0008, 32'h5151_5151, 32'h6262_6262, 32'h7373_7373},
                {32'h8123_4567, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
                32'h3000_0008, -1, -1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
